// File: rtl/pipe_collision.sv
// Pipe scroller and collision judge: moves the obstacle pipe, counts passes,
// and raises Stop on a crash until the physics block acknowledges it.
module pipe_collision #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PIPE_W      = 40,
    parameter int unsigned GAP_H       = 120,
    parameter int unsigned GAP_BASE    = 40,
    parameter int unsigned BIRD_SIZE   = 10,
    parameter int unsigned SCROLL_STEP = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               Tick,
    input  logic               Start,
    input  logic               Ack,
    input  logic signed [9:0]  Bird_X,
    input  logic signed [9:0]  Bird_Y,
    output logic               Stop,
    output logic signed [10:0] Pipe_X,
    output logic [9:0]         Gap_Y,
    output logic [7:0]         Score,
    output logic               q_Idle,
    output logic               q_Run,
    output logic               q_Hit
);

    localparam logic signed [11:0] SW12   = 12'(SCREEN_W);
    localparam logic signed [11:0] SH12   = 12'(SCREEN_H);
    localparam logic signed [11:0] PW12   = 12'(PIPE_W);
    localparam logic signed [11:0] GH12   = 12'(GAP_H);
    localparam logic signed [11:0] BS12   = 12'(BIRD_SIZE);
    localparam logic signed [11:0] STEP12 = 12'(SCROLL_STEP);
    localparam logic [9:0]         GAP_RST = 10'(GAP_BASE) + 10'(LFSR_SEED);

    typedef enum logic [2:0] {
        QIdle = 3'b001,
        QRun  = 3'b010,
        QHit  = 3'b100
    } state_t;

    state_t             state, state_nxt;
    logic signed [10:0] pipe_x_nxt;
    logic [9:0]         gap_y_nxt;
    logic [7:0]         score_nxt;
    logic [7:0]         lfsr, lfsr_nxt, lfsr_adv;
    logic signed [11:0] bx, by, px, gy, nx;
    logic               oob, xov, ingap, hit, wrap, passed;

    // Collision and scroll terms, all in 12-bit signed arithmetic
    always_comb begin
        bx       = {{2{Bird_X[9]}}, Bird_X};
        by       = {{2{Bird_Y[9]}}, Bird_Y};
        px       = {Pipe_X[10], Pipe_X};
        gy       = {2'b00, Gap_Y};
        nx       = px - STEP12;
        oob      = (by < 12'sd0) || (by + BS12 > SH12);
        xov      = (bx + BS12 > px) && (bx < px + PW12);
        ingap    = (by >= gy) && (by + BS12 <= gy + GH12);
        hit      = oob || (xov && !ingap);
        wrap     = (nx <= -PW12);
        passed   = (px + PW12 > bx) && (nx + PW12 <= bx);
        lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt  = state;
        pipe_x_nxt = Pipe_X;
        gap_y_nxt  = Gap_Y;
        score_nxt  = Score;
        lfsr_nxt   = lfsr;
        unique case (state)
            QIdle: begin
                pipe_x_nxt = 11'(SW12);
                if (Start) begin
                    state_nxt = QRun;
                    score_nxt = 8'd0;
                end
            end
            QRun: begin
                if (hit) begin
                    state_nxt = QHit;
                end else if (Tick) begin
                    if (wrap) begin
                        pipe_x_nxt = 11'(SW12);
                        lfsr_nxt   = lfsr_adv;
                        gap_y_nxt  = 10'(GAP_BASE) + 10'(lfsr_adv);
                    end else begin
                        pipe_x_nxt = 11'(nx);
                    end
                    if (passed && (Score != 8'hFF)) begin
                        score_nxt = Score + 8'd1;
                    end
                end
            end
            QHit: begin
                if (Ack) begin
                    state_nxt = QIdle;
                end
            end
            default: state_nxt = QIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state  <= QIdle;
            Pipe_X <= 11'(SW12);
            Gap_Y  <= GAP_RST;
            Score  <= 8'd0;
            lfsr   <= LFSR_SEED;
        end else begin
            state  <= state_nxt;
            Pipe_X <= pipe_x_nxt;
            Gap_Y  <= gap_y_nxt;
            Score  <= score_nxt;
            lfsr   <= lfsr_nxt;
        end
    end

    // One-hot state bits are the flops themselves; Stop mirrors the hit state
    assign q_Idle = state[0];
    assign q_Run  = state[1];
    assign q_Hit  = state[2];
    assign Stop   = state[2];

endmodule

// File: doc/pipe_collision.md
# pipe_collision

Pipe scroller and collision judge for the Flappy-VGA game. It drives the single obstacle pipe (horizontal position, gap height, score) and watches the bird coordinates produced by the flight-physics block. It is the other end of that block's Start/Stop/Ack game handshake: it raises `Stop` on a crash and holds it until `Ack`. Its outputs feed the VGA renderer and the physics block.

## Interface
Parameters:
- `SCREEN_W`, 640: screen width; pipe spawn X.
- `SCREEN_H`, 480: screen height; floor limit.
- `PIPE_W`, 40: pipe width in pixels.
- `GAP_H`, 120: vertical gap height.
- `GAP_BASE`, 40: minimum gap top.
- `BIRD_SIZE`, 10: bird square edge.
- `SCROLL_STEP`, 2: pixels per `Tick`.
- `LFSR_SEED`, 8'hA5: non-zero LFSR reset value.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `Tick`  in  1  one-cycle frame-rate enable.
- `Start`  in  1  begin a run (honoured in QIdle only).
- `Ack`  in  1  acknowledge crash (honoured in QHit only).
- `Bird_X`  in  10 signed  bird left edge.
- `Bird_Y`  in  10 signed  bird top edge.
- `Stop`  out  1  crash flag to the physics block.
- `Pipe_X`  out  11 signed  pipe left edge.
- `Gap_Y`  out  10 unsigned  top of the gap.
- `Score`  out  8  pipes passed, saturating at 255.
- `q_Idle`, `q_Run`, `q_Hit`  out  1 each  one-hot state.

## Operation
- State is one-hot {q_Hit,q_Run,q_Idle}: QIdle=001, QRun=010, QHit=100.
- **Reset (`reset`=0):** state QIdle, `Pipe_X`=SCREEN_W, LFSR=LFSR_SEED, `Gap_Y`=GAP_BASE+LFSR_SEED (205), `Score`=0, `Stop`=0. Reset applies immediately and asynchronously, including mid-run.
- **QIdle:** `Pipe_X` is held at SCREEN_W; `Score` is held so the last result stays visible. On `Start`: go to QRun, `Score`←0, `Pipe_X`←SCREEN_W.
- **QRun:**
  - Every cycle, evaluate the following with 12-bit signed arithmetic:
    - `oob` = Bird_Y<0 or Bird_Y+BIRD_SIZE>SCREEN_H.
    - `xov` = Bird_X+BIRD_SIZE>Pipe_X and Bird_X<Pipe_X+PIPE_W.
    - `ingap` = Bird_Y≥Gap_Y and Bird_Y+BIRD_SIZE≤Gap_Y+GAP_H.
    - `hit` = oob or (xov and not ingap).
  - If `hit`: go to QHit and set `Stop`←1. Pipe, score and LFSR updates are suppressed that cycle.
  - Otherwise, on `Tick`, let nx = Pipe_X−SCROLL_STEP:
    - If nx ≤ −PIPE_W: wrap. `Pipe_X`←SCREEN_W, LFSR advances, `Gap_Y`←GAP_BASE+new LFSR.
    - Else `Pipe_X`←nx.
    - If Pipe_X+PIPE_W>Bird_X and nx+PIPE_W≤Bird_X: `Score`←Score+1, saturating at 255.
- **QHit:** `Pipe_X`, `Gap_Y` and `Score` are frozen and `Stop`=1. On `Ack`: go to QIdle with `Stop`←0.
- **LFSR:** 8-bit, shifts left, feedback = l[7]^l[5]^l[4]^l[3]. A5 is followed by 4A.
- **Ignored inputs:**
  - `Start` outside QIdle.
  - `Ack` outside QHit.
  - `Tick` in QIdle and QHit.
  - `Tick` in the same cycle as `Start`.

## Timing
- All outputs are registered.
- `Stop` rises on the edge after the cycle in which `hit` is true. This is one cycle of latency, independent of `Tick`.
- `Start` leads to `q_Run` on the next edge. `Ack` leads to `q_Idle` with `Stop`=0 on the next edge.
- `Pipe_X` moves once per `Tick` in QRun. A wrap and its new `Gap_Y` update on the same edge.
- `Stop` equals `q_Hit` at all times.

## Test plan
- **Reset:** hold `reset`=0 → q_Idle=1, Pipe_X=640, Gap_Y=205, Score=0, Stop=0.
- **Scroll:** Start, bird (100,220), 10 Ticks → Pipe_X=620, Stop=0, q_Run=1.
- **Pipe crash:** bird (100,100), Ticks until Pipe_X=108 (266 Ticks) → Stop=1 one cycle later. Pipe_X stays 108 through 20 further Ticks.
- **Pass and wrap:** bird (100,220).
  - Tick 290 (Pipe_X=60) → Score=1.
  - Tick 340 → Pipe_X=640, Gap_Y=114.
  - No Stop throughout.
- **Bounds:** in QRun with no Tick, Bird_Y=−1 → Stop=1 next cycle. Repeat with Bird_Y=471 → Stop=1.
- **Handshake and reset:**
  - In QHit, Ack=1 → q_Idle, Stop=0, Score retained.
  - Next Start → Score=0.
  - `reset`=0 asserted mid-QRun → reset values immediately, without waiting for a clock edge.
